// File: rtl/varredura_teclado_pkg.sv
// Shared definitions for the key matrix scanner: FSM states, default
// matrix geometry and width helpers.
package varredura_teclado_pkg;

   typedef enum logic [1:0] {
      OCIOSO      = 2'd0,
      CONFIRMANDO = 2'd1,
      PRESSIONADA = 2'd2,
      SOLTANDO    = 2'd3
   } estado_t;

   localparam int N_LIN_PADRAO = 5;
   localparam int N_COL_PADRAO = 7;

   // Bits needed to index n items, never less than one.
   function automatic int largura(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Key code width for an n_lin x n_col matrix.
   function automatic int code_w(input int n_lin, input int n_col);
      return largura(n_lin * n_col);
   endfunction

endpackage

// File: rtl/varredura_teclado_divisor_varredura.sv
// Scan timebase: one tick every DIV_SCAN clocks, rotating an active-low
// one-hot column drive from the highest column down to column 0.
module divisor_varredura
   import varredura_teclado_pkg::*;
#(
   parameter int N_COL    = N_COL_PADRAO,
   parameter int DIV_SCAN = 5000
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       tick,
   output logic                       fim_quadro,
   output logic [largura(N_COL)-1:0]  col_idx,
   output logic [N_COL-1:0]           coluna
);

   localparam int TW    = largura(DIV_SCAN);
   localparam int COL_W = largura(N_COL);

   logic [TW-1:0] cont;

   assign tick       = (cont == TW'(DIV_SCAN - 1));
   assign fim_quadro = tick && (col_idx == '0);
   assign coluna     = ~(N_COL'(1) << col_idx);

   // Dwell counter: wraps on the tick cycle.
   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (rst)       cont <= '0;
      else if (tick) cont <= '0;
      else           cont <= cont + TW'(1);
   end

   // Column rotator: N_COL-1 down to 0, then back to N_COL-1.
   always_ff @(posedge clk) begin
      if (rst)
         col_idx <= COL_W'(N_COL - 1);
      else if (tick)
         col_idx <= (col_idx == '0) ? COL_W'(N_COL - 1) : col_idx - COL_W'(1);
   end

endmodule

// File: rtl/varredura_teclado.sv
// 5x7 key matrix scanner: synchronizes the row lines, debounces over whole
// scan frames and presents each accepted key with a valid/ack handshake.
module varredura_teclado
   import varredura_teclado_pkg::*;
#(
   parameter int N_LIN    = N_LIN_PADRAO,
   parameter int N_COL    = N_COL_PADRAO,
   parameter int DIV_SCAN = 5000,
   parameter int DEBOUNCE = 4,
   parameter int CODE_W   = code_w(N_LIN, N_COL)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_LIN-1:0]  linha,
   output logic [N_COL-1:0]  coluna,
   output logic [CODE_W-1:0] tecla_codigo,
   output logic              tecla_valida,
   input  logic              tecla_ack,
   output logic              tecla_press,
   output logic              sobrecarga
);

   localparam int COL_W = largura(N_COL);
   localparam int CNT_W = largura(DEBOUNCE + 1);

   logic              tick;
   logic              fim_quadro;
   logic [COL_W-1:0]  col_idx;
   logic [N_LIN-1:0]  sinc1, sinc2;
   logic              hit_agora, hit_acc, hit_quadro;
   logic [CODE_W-1:0] cod_agora, cod_acc, cod_quadro;
   estado_t           estado, estado_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [CODE_W-1:0] cand, cand_n;
   logic              aceita;
   logic              ack_ok;

   divisor_varredura #(
      .N_COL    (N_COL),
      .DIV_SCAN (DIV_SCAN)
   ) u_divisor (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .fim_quadro (fim_quadro),
      .col_idx    (col_idx),
      .coluna     (coluna)
   );

   // Two-flop synchronizer for the asynchronous row lines.
   // NOTE: cleared on reset; the first sample is taken DIV_SCAN>=4 clocks
   // later, so the flops have refilled with real row levels by then.
   always_ff @(posedge clk) begin
      if (rst) begin
         sinc1 <= '0;
         sinc2 <= '0;
      end else begin
         sinc1 <= linha;
         sinc2 <= sinc1;
      end
   end

   // Lowest low row in the column being driven, turned into a key code.
   // NOTE: every output gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      int lin_sel;
      hit_agora = 1'b0;
      lin_sel   = 0;
      for (int i = N_LIN - 1; i >= 0; i--) begin
         if (!sinc2[i]) begin
            hit_agora = 1'b1;
            lin_sel   = i;
         end
      end
      cod_agora = CODE_W'(lin_sel * N_COL) + CODE_W'(col_idx);
   end

   // Frame result: the first column of the frame with a hit wins.
   assign hit_quadro = hit_acc | hit_agora;
   assign cod_quadro = hit_acc ? cod_acc : cod_agora;

   // Per-frame hit accumulator, restarted on every frame-end tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_acc <= 1'b0;
         cod_acc <= '0;
      end else if (tick) begin
         if (fim_quadro) begin
            hit_acc <= 1'b0;
            cod_acc <= '0;
         end else if (hit_agora && !hit_acc) begin
            hit_acc <= 1'b1;
            cod_acc <= cod_agora;
         end
      end
   end

   // Debounce FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado <= OCIOSO;
         cnt    <= '0;
         cand   <= '0;
      end else begin
         estado <= estado_n;
         cnt    <= cnt_n;
         cand   <= cand_n;
      end
   end

   // Debounce FSM next state, evaluated only on the frame-end tick.
   always_comb begin
      estado_n = estado;
      cnt_n    = cnt;
      cand_n   = cand;
      aceita   = 1'b0;
      if (fim_quadro) begin
         case (estado)
            OCIOSO: begin
               if (hit_quadro) begin
                  cand_n = cod_quadro;
                  cnt_n  = CNT_W'(1);
                  if (DEBOUNCE == 1) begin
                     aceita   = 1'b1;
                     estado_n = PRESSIONADA;
                  end else begin
                     estado_n = CONFIRMANDO;
                  end
               end
            end
            CONFIRMANDO: begin
               if (hit_quadro && cod_quadro == cand) begin
                  cnt_n = cnt + CNT_W'(1);
                  if (cnt_n == CNT_W'(DEBOUNCE)) begin
                     aceita   = 1'b1;
                     estado_n = PRESSIONADA;
                  end
               end else begin
                  estado_n = OCIOSO;
               end
            end
            PRESSIONADA: begin
               if (!hit_quadro) begin
                  cnt_n    = CNT_W'(1);
                  estado_n = (DEBOUNCE == 1) ? OCIOSO : SOLTANDO;
               end
            end
            SOLTANDO: begin
               if (hit_quadro) begin
                  estado_n = PRESSIONADA;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
                  if (cnt_n == CNT_W'(DEBOUNCE)) estado_n = OCIOSO;
               end
            end
            default: estado_n = OCIOSO;
         endcase
      end
   end

   assign ack_ok      = tecla_valida & tecla_ack;
   assign tecla_press = (estado == PRESSIONADA) || (estado == SOLTANDO);

   // Output handshake: load on accept unless a code is still unacknowledged.
   always_ff @(posedge clk) begin
      if (rst) begin
         tecla_codigo <= '0;
         tecla_valida <= 1'b0;
         sobrecarga   <= 1'b0;
      end else begin
         if (aceita && (!tecla_valida || ack_ok)) begin
            tecla_codigo <= cod_quadro;
            tecla_valida <= 1'b1;
         end else if (ack_ok) begin
            tecla_valida <= 1'b0;
         end
         if (ack_ok)
            sobrecarga <= 1'b0;
         else if (aceita && tecla_valida)
            sobrecarga <= 1'b1;
      end
   end

endmodule

// File: tb/tb_varredura_teclado.sv
// Directed bench for varredura_teclado with DIV_SCAN=4, DEBOUNCE=2.
module tb_varredura_teclado;

   localparam int N_LIN  = 5;
   localparam int N_COL  = 7;
   localparam int QUADRO = 28;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_LIN-1:0] linha;
   logic [N_COL-1:0] coluna;
   logic [5:0]       tecla_codigo;
   logic             tecla_valida;
   logic             tecla_ack;
   logic             tecla_press;
   logic             sobrecarga;

   bit [N_LIN*N_COL-1:0] teclas;
   int                   n_assert = 0;
   int                   n_fail   = 0;
   logic [5:0]           sb_q[$];

   varredura_teclado #(
      .N_LIN    (N_LIN),
      .N_COL    (N_COL),
      .DIV_SCAN (4),
      .DEBOUNCE (2),
      .CODE_W   (6)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .linha        (linha),
      .coluna       (coluna),
      .tecla_codigo (tecla_codigo),
      .tecla_valida (tecla_valida),
      .tecla_ack    (tecla_ack),
      .tecla_press  (tecla_press),
      .sobrecarga   (sobrecarga)
   );

   always #5 clk = ~clk;

   // Switch matrix: a closed key pulls its row low while its column is driven.
   always_comb begin
      linha = '1;
      for (int r = 0; r < N_LIN; r++)
         for (int c = 0; c < N_COL; c++)
            if (teclas[r*N_COL + c] && !coluna[c]) linha[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ciclos(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic aperta(input int r, input int c);
      teclas[r*N_COL + c] = 1'b1;
   endtask

   // Bounded wait for tecla_valida, then compare the code with the scoreboard.
   task automatic espera_valida(input string tag, input int limite);
      int n = 0;
      while (!tecla_valida && n < limite) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, tecla_valida, 1);
      check({tag, "_sb_pending"}, sb_q.size() != 0, 1);
      if (tecla_valida && sb_q.size() != 0) check({tag, "_code"}, tecla_codigo, sb_q.pop_front());
   endtask

   task automatic pulso_ack();
      tecla_ack = 1'b1;
      ciclos(1);
      tecla_ack = 1'b0;
   endtask

   initial begin
      int n;
      teclas    = '0;
      tecla_ack = 1'b0;
      rst       = 1'b1;
      ciclos(3);

      // 1: reset state and scan rotation
      check("rst_coluna", coluna, 7'b0111111);
      check("rst_codigo", tecla_codigo, 0);
      check("rst_valida", tecla_valida, 0);
      check("rst_press", tecla_press, 0);
      check("rst_sobrecarga", sobrecarga, 0);
      rst = 1'b0;
      ciclos(3);
      check("scan_hold_col6", coluna, 7'b0111111);
      ciclos(1);
      check("scan_col5", coluna, 7'b1011111);
      ciclos(20);
      check("scan_col0", coluna, 7'b1111110);
      ciclos(4);
      check("scan_wrap", coluna, 7'b0111111);

      // 2: single key (row 2, col 3), one event, ack clears valid
      aperta(2, 3);
      sb_q.push_back(6'd17);
      espera_valida("t2", 5*QUADRO);
      check("t2_press", tecla_press, 1);
      ciclos(QUADRO);
      check("t2_no_repeat_valid", tecla_valida, 1);
      check("t2_no_repeat_code", tecla_codigo, 17);
      pulso_ack();
      check("t2_ack_clears", tecla_valida, 0);
      teclas = '0;
      ciclos(3*QUADRO);
      check("t2_release_press", tecla_press, 0);
      check("t2_single_event", tecla_valida, 0);

      // 3: one-frame glitch on key 0
      aperta(0, 0);
      ciclos(QUADRO);
      teclas = '0;
      ciclos(4*QUADRO);
      check("t3_glitch_valid", tecla_valida, 0);
      check("t3_glitch_press", tecla_press, 0);
      check("t3_glitch_sobrecarga", sobrecarga, 0);

      // 4: two keys in the same column, lowest row wins
      aperta(1, 4);
      aperta(3, 4);
      sb_q.push_back(6'd11);
      espera_valida("t4", 5*QUADRO);
      pulso_ack();
      check("t4_ack_clears", tecla_valida, 0);
      teclas = '0;
      ciclos(3*QUADRO);
      check("t4_release_press", tecla_press, 0);

      // 5: second accept without ack -> dropped, sobrecarga
      aperta(0, 0);
      sb_q.push_back(6'd0);
      espera_valida("t5", 5*QUADRO);
      teclas = '0;
      ciclos(3*QUADRO);
      check("t5_release_press", tecla_press, 0);
      aperta(4, 6);
      n = 0;
      while (!sobrecarga && n < 5*QUADRO) begin
         @(negedge clk);
         n++;
      end
      check("t5_sobrecarga", sobrecarga, 1);
      check("t5_valid_kept", tecla_valida, 1);
      check("t5_code_kept", tecla_codigo, 0);
      pulso_ack();
      check("t5_ack_valid", tecla_valida, 0);
      check("t5_ack_sobrecarga", sobrecarga, 0);
      teclas = '0;
      ciclos(3*QUADRO);
      check("t5_dropped_no_event", tecla_valida, 0);

      // 6: reset during debounce, ignored ack, then exact accept latency
      rst = 1'b1;
      ciclos(2);
      rst = 1'b0;
      aperta(2, 3);
      ciclos(40);
      check("t6_confirming_valid", tecla_valida, 0);
      rst = 1'b1;
      teclas = '0;
      ciclos(1);
      check("t6_rst_coluna", coluna, 7'b0111111);
      check("t6_rst_press", tecla_press, 0);
      rst = 1'b0;
      ciclos(3*QUADRO);
      check("t6_no_event", tecla_valida, 0);
      pulso_ack();
      check("t6_idle_ack_valid", tecla_valida, 0);
      check("t6_idle_ack_sobrecarga", sobrecarga, 0);

      rst = 1'b1;
      ciclos(1);
      rst = 1'b0;
      aperta(0, 5);
      sb_q.push_back(6'd5);
      ciclos(55);
      check("t6_latency_early", tecla_valida, 0);
      ciclos(1);
      check("t6_latency_valid", tecla_valida, 1);
      check("t6_latency_press", tecla_press, 1);
      check("t6_latency_sb_pending", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) check("t6_latency_code", tecla_codigo, sb_q.pop_front());
      ciclos(QUADRO);
      check("t6_valid_held", tecla_valida, 1);
      pulso_ack();
      check("t6_ack_clears", tecla_valida, 0);
      teclas = '0;
      ciclos(3*QUADRO);

      check("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
